multiword_add_seq: RTL and testbench
====================================

Name: multiword_add_seq

Overview:
- Multi-cycle sequencer that adds or subtracts two wide operands of N*WORDS bits using a single N-bit carry-lookahead adder slice.
- Processes one N-bit word per cycle, LSW first, and chains the carry through a carry register.
- Sits between a requester (valid/ready command port) and a consumer (valid/ready result port).
- Lets wide arithmetic reuse the team's narrow adder instead of instantiating a full-width one.

Parameters:
- N, 8, width of the adder slice in bits (N >= 1).
- WORDS, 4, number of slices per operation (WORDS >= 1); total width W = N*WORDS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_valid  in  1  command valid.
- start_ready  out  1  block can accept a command.
- a  in  W  operand A; sampled only on command handshake.
- b  in  W  operand B; sampled only on command handshake.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- sum  out  W  result word.
- cout  out  1  final carry out; for sub, 1 means no borrow (A >= B unsigned).
- overflow  out  1  two's-complement signed overflow of the W-bit operation.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n); the clock is clk.
- On reset assertion, immediately: state=IDLE, sum=0, cout=0, overflow=0, res_valid=0, busy=0, word index=0, carry register=0. start_ready=1 once in IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: latch a into op_a, latch (sub ? ~b : b) into op_b, set carry register to (sub ? 1 : cin), set idx=0, clear sum, go to RUN.
- RUN:
  - start_ready=0, busy=1.
  - Each cycle, the slice adds op_a[idx*N +: N] + op_b[idx*N +: N] + carry register.
  - The slice result is written to sum[idx*N +: N], the slice carry-out goes to the carry register, and idx increments.
  - When idx==WORDS-1, the cycle's carry-out is written to cout, overflow is computed, and the state goes to DONE.
  - Exactly WORDS cycles are spent in RUN.
- Overflow rule: overflow = (op_a[W-1] == op_b[W-1]) & (sum[W-1] != op_a[W-1]), where op_b is the effective (possibly inverted) B.
- DONE:
  - res_valid=1; sum, cout and overflow are held stable.
  - On res_valid & res_ready, go to IDLE and drop res_valid the next cycle. sum, cout and overflow keep their values until the next command starts.
  - While res_ready=0, the block stays in DONE indefinitely with all outputs held.
- Latency:
  - Command accepted at edge T gives res_valid=1 after edge T+WORDS.
  - Minimum issue interval is WORDS+2 cycles (DONE handshake cycle, then IDLE accept cycle).
  - start_ready is never high outside IDLE, so there is no command/result overlap.
- Operand isolation: changes on a, b, cin and sub after the handshake have no effect on the operation in progress.
- WORDS=1: one RUN cycle; the behaviour is identical to a registered single-slice add.
- Wrap-around: the sum is modulo 2^W. The carry out of the top slice appears only on cout and is never fed back into the next command.
- Reset mid-operation (RUN or DONE): the operation is abandoned and the reset values above apply. No partial result is ever presented with res_valid=1.
- start_valid while not in IDLE is ignored and no command is latched.
- The slice is the existing N-bit carry-lookahead adder, instantiated once. It is driven only by registered state and contains no state of its own.

Test Plan:
- N=8, WORDS=4, add, a=0x000000FF, b=0x00000001, cin=0 -> res_valid 4 cycles after accept; sum=0x00000100, cout=0, overflow=0.
- Add a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, overflow=0 (carry ripples across all 4 slices via the carry register).
- Sub a=5, b=7 -> sum=0xFFFFFFFE, cout=0 (borrow), overflow=0. Then sub a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
- Add a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, overflow=1, cout=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles after res_valid rises; toggle a/b and pulse start_valid during that time.
  - Required: sum, cout and overflow stay stable; start_ready=0; no new command is taken; after res_ready=1, IDLE is reached and the next command is accepted 1 cycle later.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously (between clock edges) during the second RUN cycle.
  - Required: outputs clear immediately (res_valid=0, sum=0, busy=0) with no clock needed. After release, start_ready=1 and a fresh add 0x12345678+0x11111111 gives 0x23456789.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: streams N-bit words, LSW first, through one
// carry-lookahead slice and chains the carry through a register.
module multiword_add_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               overflow,
    output logic               busy
);

    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // Slice operands come only from registered state.
    logic [N-1:0] sl_a, sl_b, sl_sum;
    logic [N-1:0] sl_g, sl_p;
    logic [N:0]   sl_c;
    logic         sl_pp;

    assign sl_a = op_a_q[idx_q*N +: N];
    assign sl_b = op_b_q[idx_q*N +: N];

    // N-bit carry-lookahead slice: every carry is a flat sum of generate terms.
    always_comb begin
        sl_g  = sl_a & sl_b;
        sl_p  = sl_a ^ sl_b;
        sl_c  = '0;
        sl_pp = 1'b0;
        sl_c[0] = carry_q;
        for (int i = 0; i < int'(N); i++) begin
            sl_c[i+1] = sl_g[i];
            sl_pp     = sl_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                sl_c[i+1] = sl_c[i+1] | (sl_g[j] & sl_pp);
                sl_pp     = sl_pp & sl_p[j];
            end
            sl_c[i+1] = sl_c[i+1] | (carry_q & sl_pp);
        end
        sl_sum = sl_p ^ sl_c[N-1:0];
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*N +: N] = sl_sum;
                carry_d = sl_c[N];
                if (idx_q == LastIdx) begin
                    cout_d  = sl_c[N];
                    ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) && (sl_sum[N-1] != op_a_q[W-1]);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == StIdle);
    assign res_valid   = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed and random operations against a
// full-width arithmetic reference, plus backpressure and mid-run reset.
module tb_multiword_add_seq;

    localparam int unsigned N     = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout, overflow, busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout, exp_ovf;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: whole-width arithmetic on the operands as given.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mcin, input logic msub);
        logic [W-1:0] eb;
        logic [W:0]   t;
        eb = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, eb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
        exp_sum  = t[W-1:0];
        exp_cout = t[W];
        exp_ovf  = (ma[W-1] == eb[W-1]) && (t[W-1] != ma[W-1]);
    endtask

    // Called at #1 after an edge while idle; the command is taken at the next edge.
    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub);
        a = ta; b = tb_; cin = tcin; sub = tsub; start_valid = 1'b1;
        model(ta, tb_, tcin, tsub);
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_ready_low", 64'(start_ready), 64'd0);
        // Scramble inputs to show the running operation ignores them.
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic await_result(input string tag);
        repeat (WORDS - 1) begin
            @(posedge clk); #1;
            chk({tag, "_early_valid"}, 64'(res_valid), 64'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({tag, "_rel_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_rel_ready"}, 64'(start_ready), 64'd1);
        chk({tag, "_rel_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rel_sum_hold"}, 64'(sum), 64'(exp_sum));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub);
        accept(ta, tb_, tcin, tsub);
        await_result(tag);
        release_result(tag);
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 64'(start_ready), 64'd1);

        // Directed cases; the carry-out of the first must not leak into the next.
        run_op("carry_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        chk("carry_ripple_const_sum", 64'(exp_sum), 64'h0);
        run_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b0 | 1'b1);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sub_ignore_cin", 32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        // Backpressure: result held, commands refused while DONE.
        accept(32'h1357_9BDF, 32'h0246_8ACE, 1'b1, 1'b0);
        await_result("bp");
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; start_valid = ~start_valid;
            @(posedge clk); #1;
            chk($sformatf("bp_hold_valid%0d", i), 64'(res_valid), 64'd1);
            chk($sformatf("bp_hold_ready%0d", i), 64'(start_ready), 64'd0);
            chk($sformatf("bp_hold_sum%0d", i), 64'(sum), 64'(exp_sum));
            chk($sformatf("bp_hold_cout%0d", i), 64'(cout), 64'(exp_cout));
            chk($sformatf("bp_hold_ovf%0d", i), 64'(overflow), 64'(exp_ovf));
        end
        start_valid = 1'b0;
        release_result("bp");
        run_op("bp_next", 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b1);

        // Asynchronous reset during the second RUN cycle.
        accept(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(start_ready), 64'd1);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(start_ready), 64'd1);
        run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        chk("post_rst_expect", 64'(exp_sum), 64'h2345_6789);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
